rip_ro_freq_counter: RTL and testbench
======================================

RIP_RO_FREQ_COUNTER -- requirements
Module: rip_ro_freq_counter

Interface
REQ-001 SHALL have parameter GATE_CYCLES, default 1024: measurement window length in clk cycles, >=1.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 4: warm-up cycles after oscillator enable, >=SYNC_STAGES.
REQ-003 SHALL have parameter COUNT_W, default 16: edge-counter and result width.
REQ-004 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth, >=2.
REQ-005 SHALL have port clk, input, 1: the single system clock.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1: one-cycle request to begin a measurement.
REQ-008 SHALL have port abort, input, 1: cancel the measurement in progress.
REQ-009 SHALL have port ro_in, input, 1: asynchronous ring-oscillator output being measured.
REQ-010 SHALL have port ro_en, output, 1: active-high oscillator enable, intended to drive the oscillator's active-low reset input.
REQ-011 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-012 SHALL have port count, output, COUNT_W: rising-edge count from the last completed window.
REQ-013 SHALL have port overflow, output, 1: the last completed window saturated.
REQ-014 SHALL have port valid, output, 1: one-cycle pulse when count and overflow update.

Function
REQ-015 SHALL pass ro_in through a SYNC_STAGES flop chain and detect rising edges by comparing the synchronized value with its value one cycle earlier.
REQ-016 SHALL implement the FSM IDLE -> SETTLE -> COUNT -> DONE -> IDLE.
REQ-017 IDLE: ro_en=0, busy=0; start=1 SHALL transition to SETTLE on the next cycle.
REQ-018 SETTLE: ro_en=1 for exactly SETTLE_CYCLES cycles; edges SHALL NOT be counted; the edge counter SHALL be cleared; then the FSM transitions to COUNT.
REQ-019 COUNT: ro_en=1 for exactly GATE_CYCLES cycles; each detected edge SHALL increment the counter; an edge in the final COUNT cycle SHALL be counted.
REQ-020 On an increment from all-ones, the counter SHALL saturate at all-ones and set a sticky overflow flag for the window.
REQ-021 DONE: one cycle; count and overflow SHALL load and valid=1; ro_en=0 unless continuous mode is active (REQ-029).
REQ-022 Latency: with start sampled high in cycle T, valid SHALL be high in cycle T+1+SETTLE_CYCLES+GATE_CYCLES.
REQ-023 start while busy SHALL be ignored.
REQ-024 abort in SETTLE, COUNT or DONE SHALL force IDLE next cycle with no valid pulse, count and overflow unchanged, and ro_en=0 from the next cycle.
REQ-025 abort has priority over start and over completion when they occur in the same cycle.
REQ-026 count and overflow SHALL hold their values between valid pulses.

Reset
REQ-027 rst=1 at a clk edge SHALL force IDLE, ro_en=0, busy=0, valid=0, count=0, overflow=0, clear the edge counter, gate counter and synchronizer flops, and discard any measurement in progress.

Configuration
REQ-028 Without RIP_RO_FREQ_CONTINUOUS_EN, the block SHALL be single-shot as described above.
REQ-029 With RIP_RO_FREQ_CONTINUOUS_EN defined:
- DONE SHALL return directly to COUNT with the counter cleared and ro_en held at 1, without a SETTLE phase.
- Successive valid pulses SHALL be exactly GATE_CYCLES+1 cycles apart.
- Only abort or rst SHALL stop the measurement.

Structure
REQ-030 A shared package rip_ro_pkg SHALL hold the FSM state enum (IDLE, SETTLE, COUNT, DONE) and default parameter constants.
REQ-031 The synchronizer SHALL be a sub-module rip_sync_ff, parameterized by stage count and reusable elsewhere.

Verification
REQ-032 ro_in toggles every 5 clk cycles (period 10), GATE_CYCLES=100 -> single valid, count in {10,11}, overflow=0.
REQ-033 ro_in held 0, start -> valid at T+1+SETTLE_CYCLES+GATE_CYCLES, count=0, ro_en high exactly SETTLE_CYCLES+GATE_CYCLES cycles.
REQ-034 COUNT_W=4, ro_in period 4 clk, GATE_CYCLES=100 -> count=15, overflow=1.
REQ-035 abort at COUNT cycle 50 -> no valid, ro_en=0 next cycle, previous count retained; start during busy -> no second measurement.
REQ-036 rst asserted mid-COUNT -> next cycle all outputs 0; with RIP_RO_FREQ_CONTINUOUS_EN and GATE_CYCLES=100, valid pulses 101 cycles apart.

Source files
------------

// File: rtl/rip_ro_pkg.sv
// Shared types and default constants for the ring-oscillator frequency counter.
// Holds the measurement FSM state encoding and a timer sizing helper.
package rip_ro_pkg;

    localparam int DEF_GATE_CYCLES   = 1024;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_COUNT_W       = 16;
    localparam int DEF_SYNC_STAGES   = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        COUNT  = 2'd2,
        DONE   = 2'd3
    } ro_state_e;

    // Width of a phase timer that must reach max(a, b) - 1.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage : rip_ro_pkg

// File: rtl/rip_sync_ff.sv
// Generic multi-flop synchronizer for a single asynchronous bit; STAGES >= 2.
// Synchronous active-high reset loads RESET_VAL into every stage.
module rip_sync_ff #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // NOTE: clocked state always uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule : rip_sync_ff

// File: rtl/rip_ro_freq_counter.sv
// Ring-oscillator frequency counter: enables the oscillator, lets it settle, then counts
// synchronized ro_in rising edges over GATE_CYCLES clocks. Define RIP_RO_FREQ_CONTINUOUS_EN for back-to-back windows.
module rip_ro_freq_counter
    import rip_ro_pkg::*;
#(
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int COUNT_W       = DEF_COUNT_W,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               ro_in,
    output logic               ro_en,
    output logic               busy,
    output logic [COUNT_W-1:0] count,
    output logic               overflow,
    output logic               valid
);

    localparam int                 TIMER_W     = timer_width(GATE_CYCLES, SETTLE_CYCLES);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] GATE_LAST   = TIMER_W'(GATE_CYCLES - 1);

    ro_state_e           state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [COUNT_W-1:0]  edge_cnt_q, edge_cnt_d;
    logic                edge_ovf_q, edge_ovf_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                ro_sync;
    logic                ro_sync_prev_q;
    logic                ro_rise;

    rip_sync_ff #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b0)
    ) u_ro_sync (
        .clk (clk),
        .rst (rst),
        .d_i (ro_in),
        .q_o (ro_sync)
    );

    assign ro_rise = ro_sync & ~ro_sync_prev_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        edge_cnt_d = edge_cnt_q;
        edge_ovf_d = edge_ovf_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        ro_en      = 1'b0;
        valid      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = SETTLE;
                    timer_d = '0;
                end
            end

            SETTLE: begin
                ro_en      = 1'b1;
                edge_cnt_d = '0;
                edge_ovf_d = 1'b0;
                if (abort) begin
                    state_d = IDLE;
                end else if (timer_q == SETTLE_LAST) begin
                    state_d = COUNT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            COUNT: begin
                ro_en = 1'b1;
                // Saturate at all-ones; the overflow flag stays set for the rest of the window.
                if (ro_rise) begin
                    if (&edge_cnt_q) begin
                        edge_ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + COUNT_W'(1);
                    end
                end
                if (abort) begin
                    state_d = IDLE;
                end else if (timer_q == GATE_LAST) begin
                    state_d = DONE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            DONE: begin
`ifdef RIP_RO_FREQ_CONTINUOUS_EN
                ro_en = 1'b1;
`endif
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    valid      = 1'b1;
                    count_d    = edge_cnt_q;
                    overflow_d = edge_ovf_q;
`ifdef RIP_RO_FREQ_CONTINUOUS_EN
                    state_d    = COUNT;
                    timer_d    = '0;
                    edge_cnt_d = '0;
                    edge_ovf_d = 1'b0;
`else
                    state_d    = IDLE;
`endif
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            timer_q        <= '0;
            edge_cnt_q     <= '0;
            edge_ovf_q     <= 1'b0;
            count_q        <= '0;
            overflow_q     <= 1'b0;
            ro_sync_prev_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            edge_cnt_q     <= edge_cnt_d;
            edge_ovf_q     <= edge_ovf_d;
            count_q        <= count_d;
            overflow_q     <= overflow_d;
            ro_sync_prev_q <= ro_sync;
        end
    end

    assign busy     = (state_q != IDLE);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule : rip_ro_freq_counter

// File: tb/tb_rip_ro_freq_counter.sv
// Self-checking bench for rip_ro_freq_counter: two instances (16-bit and 4-bit results) share stimulus,
// results are compared against an edge-history model. Honors RIP_RO_FREQ_CONTINUOUS_EN.
module tb_rip_ro_freq_counter;

    localparam int G    = 100;
    localparam int S    = 4;
    localparam int N    = 2;
    localparam int WA   = 16;
    localparam int WB   = 4;
    localparam int HMAX = 16384;

    logic          clk = 1'b0;
    logic          rst, start, abort, ro_in;
    logic          ro_en_a, busy_a, overflow_a, valid_a;
    logic [WA-1:0] count_a;
    logic          ro_en_b, busy_b, overflow_b, valid_b;
    logic [WB-1:0] count_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit hist [0:HMAX-1];

    int ro_mode  = 0;
    int ro_half  = 5;
    int ro_ph    = 0;
    bit ro_level = 1'b0;

    int exp_a = 0;
    int exp_b = 0;
    bit exp_ov_a = 1'b0;
    bit exp_ov_b = 1'b0;

    always #5 clk = ~clk;

    rip_ro_freq_counter #(
        .GATE_CYCLES(G), .SETTLE_CYCLES(S), .COUNT_W(WA), .SYNC_STAGES(N)
    ) dut_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ro_in(ro_in),
        .ro_en(ro_en_a), .busy(busy_a), .count(count_a), .overflow(overflow_a), .valid(valid_a)
    );

    rip_ro_freq_counter #(
        .GATE_CYCLES(G), .SETTLE_CYCLES(S), .COUNT_W(WB), .SYNC_STAGES(N)
    ) dut_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ro_in(ro_in),
        .ro_en(ro_en_b), .busy(busy_b), .count(count_b), .overflow(overflow_b), .valid(valid_b)
    );

    // Edge number k and the ro_in level sampled at that edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc + 1 < HMAX) hist[cyc + 1] <= ro_in;
    end

    // Oscillator stand-in: 0 = constant level, 1 = toggle every ro_half clocks, 2 = random per clock.
    initial begin
        ro_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ro_mode)
                0: ro_in = ro_level;
                1: begin
                    ro_ph++;
                    if (ro_ph >= ro_half) begin
                        ro_in = ~ro_in;
                        ro_ph = 0;
                    end
                end
                default: ro_in = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ro(input int mode, input int half, input bit level);
        ro_mode  = mode;
        ro_half  = half;
        ro_level = level;
        ro_ph    = 0;
    endtask

    // Rising edges of the sampled waveform whose synchronized detection lands on edges lo..hi.
    function automatic int model_edges(input int lo, input int hi);
        int n = 0;
        for (int k = 1; k < HMAX; k++) begin
            if (k + N >= lo && k + N <= hi && hist[k] && !hist[k-1]) n++;
        end
        return n;
    endfunction

    task automatic set_expected(input int raw);
        exp_a    = (raw > (1 << WA) - 1) ? (1 << WA) - 1 : raw;
        exp_ov_a = (raw > (1 << WA) - 1);
        exp_b    = (raw > (1 << WB) - 1) ? (1 << WB) - 1 : raw;
        exp_ov_b = (raw > (1 << WB) - 1);
    endtask

    task automatic check_results(input string tag);
        check({tag, "_count_a"}, count_a, exp_a);
        check({tag, "_ovf_a"}, overflow_a, exp_ov_a);
        check({tag, "_count_b"}, count_b, exp_b);
        check({tag, "_ovf_b"}, overflow_b, exp_ov_b);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ro_en_a"}, ro_en_a, 0);
        check({tag, "_busy_a"}, busy_a, 0);
        check({tag, "_valid_a"}, valid_a, 0);
        check({tag, "_count_a"}, count_a, 0);
        check({tag, "_ovf_a"}, overflow_a, 0);
        check({tag, "_ro_en_b"}, ro_en_b, 0);
        check({tag, "_busy_b"}, busy_b, 0);
        check({tag, "_valid_b"}, valid_b, 0);
        check({tag, "_count_b"}, count_b, 0);
        check({tag, "_ovf_b"}, overflow_b, 0);
    endtask

    // Starts in a cycle after a posedge; returns at the negedge of the valid cycle (or after budget).
    task automatic wait_valid(input int budget, input bit poke, output int vcyc, output int en_hi);
        vcyc  = -1;
        en_hi = 0;
        for (int i = 0; i < budget; i++) begin
            start = poke && (i == 1 || i == S + 20 || i == S + G);
            @(negedge clk);
            if (ro_en_a) en_hi++;
            if (valid_a) begin
                vcyc = cyc;
                check("valid_b_with_a", valid_b, 1);
                break;
            end
            next_cycle();
        end
    endtask

    task automatic measure(input string tag, input bit poke, output int raw);
        int e0, vcyc, en_hi, vexp;
        e0 = cyc + 1;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        wait_valid(S + G + 20, poke, vcyc, en_hi);
        vexp = e0 + S + G;
        check({tag, "_latency"}, vcyc, vexp);
`ifndef RIP_RO_FREQ_CONTINUOUS_EN
        check({tag, "_ro_en_cycles"}, en_hi, S + G);
`endif
        raw = model_edges(vexp - G + 1, vexp);
        set_expected(raw);
        next_cycle();
        start = 1'b0;
`ifdef RIP_RO_FREQ_CONTINUOUS_EN
        abort = 1'b1;
`endif
        @(negedge clk);
        check_results(tag);
        check({tag, "_valid_low"}, valid_a, 0);
`ifdef RIP_RO_FREQ_CONTINUOUS_EN
        next_cycle();
        abort = 1'b0;
`else
        check({tag, "_busy_after"}, busy_a, 0);
        check({tag, "_ro_en_after"}, ro_en_a, 0);
`endif
        next_cycle();
    endtask

    // Abort lands in the cycle after edge e0+i_ab (1: SETTLE, S+49: COUNT cycle 50, S+G: DONE).
    task automatic abort_at(input string tag, input int i_ab);
        int nv = 0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int i = 0; i < i_ab; i++) begin
            @(negedge clk);
            if (valid_a) nv++;
            next_cycle();
        end
        abort = 1'b1;
        @(negedge clk);
        if (valid_a) nv++;
        check({tag, "_busy_at_abort"}, busy_a, 1);
        next_cycle();
        abort = 1'b0;
        @(negedge clk);
        check({tag, "_ro_en_off"}, ro_en_a, 0);
        check({tag, "_busy_off"}, busy_a, 0);
        check_results(tag);
        for (int i = 0; i < 40; i++) begin
            next_cycle();
            @(negedge clk);
            if (valid_a) nv++;
        end
        check({tag, "_no_valid"}, nv, 0);
        next_cycle();
    endtask

    initial begin
        int raw;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_zero("reset");
        next_cycle();
        rst = 1'b0;
        repeat (6) next_cycle();

        // Period-10 oscillator over a 100-cycle window.
        set_ro(1, 5, 1'b0);
        measure("p10", 1'b0, raw);
        @(negedge clk);
        check("p10_range", (count_a >= 10 && count_a <= 11), 1);
        next_cycle();

        // Oscillator stuck low.
        set_ro(0, 1, 1'b0);
        measure("flat0", 1'b0, raw);

        // Period-4 oscillator saturates the 4-bit instance.
        set_ro(1, 2, 1'b0);
        measure("p4", 1'b0, raw);
        @(negedge clk);
        check("p4_sat_count_b", count_b, 15);
        check("p4_sat_ovf_b", overflow_b, 1);
        next_cycle();

        // start pulses in SETTLE, COUNT and DONE must not restart anything.
        set_ro(1, 3, 1'b0);
        measure("busy_start", 1'b1, raw);

        for (int t = 0; t < 8; t++) begin
            set_ro($urandom_range(0, 2), $urandom_range(1, 9), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 6)) next_cycle();
            measure($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), raw);
        end

        set_ro(1, 3, 1'b0);
        measure("pre_abort", 1'b0, raw);
        abort_at("ab_settle", 1);
        abort_at("ab_count50", S + 49);
        abort_at("ab_done", S + G);

        // abort and start together while idle: stay idle.
        start = 1'b1;
        abort = 1'b1;
        next_cycle();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle_busy", busy_a, 0);
        next_cycle();

        // Reset in the middle of COUNT after a non-zero result.
        set_ro(1, 2, 1'b0);
        measure("pre_rst", 1'b0, raw);
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (S + 30) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_zero("rst_mid");
        set_expected(0);
        repeat (6) next_cycle();
        set_ro(2, 1, 1'b0);
        measure("post_rst", 1'b0, raw);

`ifdef RIP_RO_FREQ_CONTINUOUS_EN
        begin
            int e0, vcyc, en_hi, vexp;
            set_ro(1, 3, 1'b0);
            e0 = cyc + 1;
            start = 1'b1;
            next_cycle();
            start = 1'b0;
            for (int p = 0; p < 3; p++) begin
                vexp = e0 + S + G + p * (G + 1);
                wait_valid(S + G + 20, 1'b0, vcyc, en_hi);
                check($sformatf("cont%0d_latency", p), vcyc, vexp);
                if (p > 0) check($sformatf("cont%0d_ro_en_cycles", p), en_hi, G);
                set_expected(model_edges(vexp - G + 1, vexp));
                next_cycle();
                @(negedge clk);
                check_results($sformatf("cont%0d", p));
                check($sformatf("cont%0d_ro_en_held", p), ro_en_a, 1);
                next_cycle();
            end
            abort = 1'b1;
            next_cycle();
            abort = 1'b0;
            @(negedge clk);
            check("cont_stop_ro_en", ro_en_a, 0);
            check("cont_stop_busy", busy_a, 0);
            next_cycle();
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_rip_ro_freq_counter
